icache_line_fill: RTL and testbench

ICACHE_LINE_FILL -- requirements
Module: icache_line_fill

---
 rtl/icache_line_fill.sv | 146 ++++++++++++++
 tb/tb_icache_line_fill.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_line_fill.sv
// Instruction-cache line refill engine: turns a level-held miss request into one
// fixed-length read burst and assembles the returned words into a full cache line.
module icache_line_fill #(
    parameter int WORD  = 32,
    parameter int BEATS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic [WORD-1:0]         req_addr,
    input  logic                    flush,
    output logic                    line_ready,
    output logic [WORD*BEATS-1:0]   line_data,
    output logic                    bus_arvalid,
    output logic [WORD-1:0]         bus_araddr,
    output logic [7:0]              bus_arlen,
    input  logic                    bus_arready,
    input  logic                    bus_rvalid,
    input  logic [WORD-1:0]         bus_rdata,
    input  logic                    bus_rlast,
    output logic                    bus_rready,
    output logic                    protocol_err
);

    localparam int            LINE  = WORD * BEATS;
    localparam int            CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int            OFF   = $clog2(LINE / 8);
    localparam logic [CW-1:0] LAST  = CW'(BEATS - 1);
    localparam logic [7:0]    ARLEN = 8'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic            abort;
    logic [WORD-1:0] araddr_q;
    logic            arvalid_q;
    logic            rready_q;
    logic            perr_q;
    logic [LINE-1:0] line_q;
    logic            beat;
    logic            last_beat;
    logic            ar_hs;
    logic            unused_addr_bits;

    assign beat             = bus_rvalid && rready_q;
    assign last_beat        = beat && (cnt == LAST);
    assign ar_hs            = arvalid_q && bus_arready;
    assign unused_addr_bits = ^req_addr[OFF-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid && !flush) begin
                    state_nxt = ADDR;
                end
            end
            // The address phase cannot be withdrawn; a flush only redirects
            // the burst into DRAIN once the slave has accepted it.
            ADDR: begin
                if (ar_hs) begin
                    state_nxt = (abort || flush) ? DRAIN : DATA;
                end
            end
            DATA: begin
                if (flush) begin
                    state_nxt = last_beat ? IDLE : DRAIN;
                end else if (last_beat) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            DRAIN: begin
                if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            abort     <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= '0;
            line_q    <= '0;
            perr_q    <= 1'b0;
        end else begin
            // Bus handshake outputs are decoded from the next state so they
            // leave the block straight from flops.
            arvalid_q <= (state_nxt == ADDR);
            rready_q  <= (state_nxt == DATA) || (state_nxt == DRAIN);

            if (state == IDLE && state_nxt == ADDR) begin
                araddr_q <= {req_addr[WORD-1:OFF], {OFF{1'b0}}};
            end

            if (state == ADDR && state_nxt == ADDR) begin
                abort <= abort || flush;
            end else begin
                abort <= 1'b0;
            end

            if (state == ADDR) begin
                cnt <= '0;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
            end

            if (state == DATA && beat && !flush) begin
                line_q[int'(cnt)*WORD +: WORD] <= bus_rdata;
            end

            // Completion never depends on rlast; a mismatch is only reported.
            if (beat && (bus_rlast != (cnt == LAST))) begin
                perr_q <= 1'b1;
            end
        end
    end

    assign line_ready   = (state == DONE) && !flush;
    assign line_data    = line_q;
    assign bus_arvalid  = arvalid_q;
    assign bus_araddr   = araddr_q;
    assign bus_arlen    = arvalid_q ? ARLEN : 8'd0;
    assign bus_rready   = rready_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_icache_line_fill.sv
// Self-checking bench for icache_line_fill: the bench plays the read slave and
// predicts addresses, latency, line contents and flags from the block's rules.
module tb_icache_line_fill;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         flush;
    logic         line_ready;
    logic [127:0] line_data;
    logic         bus_arvalid;
    logic [31:0]  bus_araddr;
    logic [7:0]   bus_arlen;
    logic         bus_arready;
    logic         bus_rvalid;
    logic [31:0]  bus_rdata;
    logic         bus_rlast;
    logic         bus_rready;
    logic         protocol_err;

    always #5 clk = ~clk;

    icache_line_fill #(.WORD(32), .BEATS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .flush        (flush),
        .line_ready   (line_ready),
        .line_data    (line_data),
        .bus_arvalid  (bus_arvalid),
        .bus_araddr   (bus_araddr),
        .bus_arlen    (bus_arlen),
        .bus_arready  (bus_arready),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata),
        .bus_rlast    (bus_rlast),
        .bus_rready   (bus_rready),
        .protocol_err (protocol_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0]  beat_q [4];
    int           obs_ready_cnt, obs_ready_cyc, obs_beats, obs_gaps, obs_ar_cyc;
    logic [31:0]  obs_araddr;
    logic [7:0]   obs_arlen;
    logic [127:0] obs_line;
    bit           obs_ar_unstable, obs_extra_ar, obs_timeout, obs_perr, obs_idle;

    function automatic logic [127:0] beats_line();
        return {beat_q[3], beat_q[2], beat_q[1], beat_q[0]};
    endfunction

    task automatic idle_inputs();
        req_valid   = 1'b0;
        req_addr    = 32'h0;
        flush       = 1'b0;
        bus_arready = 1'b0;
        bus_rvalid  = 1'b0;
        bus_rdata   = 32'h0;
        bus_rlast   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic new_beats();
        for (int i = 0; i < 4; i++) beat_q[i] = $urandom;
    endtask

    // Slave + requester driver. flush_at: -1 none, 0 during the address phase,
    // 1..3 after that many beats, 4 in the cycle after the last beat.
    task automatic run_txn(input logic [31:0] addr, input int ar_d, input int flush_at,
                           input int bad_beat, input bit gaps);
        int         c, ar_cnt, post;
        bit         flushed, hs, fl_now, done_before;
        logic [31:0] first_addr;
        logic [7:0]  first_len;
        c = 0; ar_cnt = 0; post = 0; flushed = 0; hs = 0;
        first_addr = '0; first_len = '0;
        obs_ready_cnt = 0; obs_ready_cyc = -1; obs_beats = 0; obs_gaps = 0; obs_ar_cyc = 0;
        obs_araddr = '0; obs_arlen = '0; obs_line = '0;
        obs_ar_unstable = 0; obs_extra_ar = 0; obs_timeout = 0;
        while (1) begin
            @(negedge clk);
            done_before = (obs_beats == 4);
            fl_now = !flushed &&
                     ((flush_at == 0 && bus_arvalid && !hs) ||
                      (flush_at >= 1 && flush_at <= 3 && bus_rready && obs_beats == flush_at) ||
                      (flush_at == 4 && obs_beats == 4 && post == 0));
            flush       = fl_now;
            req_addr    = addr;
            req_valid   = !flushed && !fl_now && (obs_ready_cnt == 0);
            bus_arready = bus_arvalid && (ar_cnt >= ar_d);
            if (bus_rready && obs_beats < 4 && !fl_now && !(gaps && $urandom_range(0, 2) == 0)) begin
                bus_rvalid = 1'b1;
                bus_rdata  = beat_q[obs_beats];
                bus_rlast  = (obs_beats == 3) ^ (obs_beats == bad_beat);
            end else begin
                if (bus_rready && obs_beats < 4 && !fl_now) obs_gaps++;
                bus_rvalid = 1'b0;
                bus_rdata  = $urandom;
                bus_rlast  = 1'b0;
            end
            #1;
            if (bus_arvalid) begin
                if (hs) begin
                    obs_extra_ar = 1;
                end else begin
                    if (ar_cnt == 0) begin
                        first_addr = bus_araddr;
                        first_len  = bus_arlen;
                    end else if (bus_araddr !== first_addr || bus_arlen !== first_len) begin
                        obs_ar_unstable = 1;
                    end
                    ar_cnt++;
                    obs_ar_cyc = ar_cnt;
                    if (bus_arready) begin
                        hs = 1;
                        obs_araddr = bus_araddr;
                        obs_arlen  = bus_arlen;
                    end
                end
            end else if (ar_cnt != 0 && !hs) begin
                obs_ar_unstable = 1;
            end
            if (bus_rvalid && bus_rready) obs_beats++;
            if (line_ready) begin
                obs_ready_cnt++;
                obs_ready_cyc = c;
                obs_line = line_data;
            end
            if (fl_now) flushed = 1;
            if (done_before) post++;
            c++;
            if (post >= 3) break;
            if (c > 300) begin
                obs_timeout = 1;
                break;
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        obs_perr = protocol_err;
        obs_idle = !bus_arvalid && !bus_rready && !line_ready;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b1; req_addr = 32'hFFFF_FFFF;
        bus_arready = 1'b1; bus_rvalid = 1'b1; bus_rlast = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if ({line_ready, bus_arvalid, bus_rready, protocol_err} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 0000", {line_ready, bus_arvalid, bus_rready, protocol_err});
        end
        n_cmp++;
        if (line_data !== 128'h0 || bus_araddr !== 32'h0 || bus_arlen !== 8'h0) begin
            n_err++;
            $display("FAIL reset_data: line=%h araddr=%h arlen=%h want all 0", line_data, bus_araddr, bus_arlen);
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        beat_q[0] = 32'hA0; beat_q[1] = 32'hA1; beat_q[2] = 32'hA2; beat_q[3] = 32'hA3;
        run_txn(32'h1C00_0034, 0, -1, -1, 0);
        n_cmp++;
        if (obs_araddr !== 32'h1C00_0030 || obs_arlen !== 8'd3) begin
            n_err++;
            $display("FAIL basic_ar: araddr=%h arlen=%0d want 1c000030/3", obs_araddr, obs_arlen);
        end
        n_cmp++;
        if (obs_ready_cnt !== 1 || obs_ready_cyc !== 6) begin
            n_err++;
            $display("FAIL basic_ready: pulses=%0d cycle=%0d want 1/6", obs_ready_cnt, obs_ready_cyc);
        end
        n_cmp++;
        if (obs_line !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            n_err++;
            $display("FAIL basic_line: got %h want 000000a3000000a2000000a1000000a0", obs_line);
        end
        repeat (4) @(negedge clk);
        #1;
        n_cmp++;
        if (line_data !== 128'h000000A3_000000A2_000000A1_000000A0 || !obs_idle || obs_extra_ar) begin
            n_err++;
            $display("FAIL basic_hold: line=%h idle=%0d extra_ar=%0d", line_data, obs_idle, obs_extra_ar);
        end
    endtask

    task automatic test_ar_stall();
        new_beats();
        run_txn(32'h8765_432C, 5, -1, -1, 0);
        n_cmp++;
        if (obs_ar_unstable || obs_ar_cyc !== 6 || obs_araddr !== 32'h8765_4320) begin
            n_err++;
            $display("FAIL stall_ar: unstable=%0d ar_cycles=%0d araddr=%h want 0/6/87654320",
                     obs_ar_unstable, obs_ar_cyc, obs_araddr);
        end
        n_cmp++;
        if (obs_ready_cyc !== 11 || obs_line !== beats_line()) begin
            n_err++;
            $display("FAIL stall_ready: cycle=%0d line=%h want 11/%h", obs_ready_cyc, obs_line, beats_line());
        end
    endtask

    task automatic test_flush_data();
        new_beats();
        run_txn(32'h0000_2040, 0, 2, -1, 0);
        n_cmp++;
        if (obs_ready_cnt !== 0 || obs_beats !== 4 || !obs_idle || obs_extra_ar || obs_timeout) begin
            n_err++;
            $display("FAIL flush_data: pulses=%0d beats=%0d idle=%0d extra_ar=%0d to=%0d want 0/4/1/0/0",
                     obs_ready_cnt, obs_beats, obs_idle, obs_extra_ar, obs_timeout);
        end
        new_beats();
        run_txn(32'h0000_0100, 0, -1, -1, 0);
        n_cmp++;
        if (obs_araddr !== 32'h0000_0100 || obs_ready_cyc !== 6 || obs_line !== beats_line()) begin
            n_err++;
            $display("FAIL flush_next: araddr=%h cycle=%0d line=%h want 00000100/6/%h",
                     obs_araddr, obs_ready_cyc, obs_line, beats_line());
        end
    endtask

    task automatic test_flush_addr();
        logic [127:0] prev;
        prev = beats_line();
        new_beats();
        run_txn(32'h0000_3000, 3, 0, -1, 0);
        n_cmp++;
        if (obs_ar_unstable || obs_ar_cyc !== 4) begin
            n_err++;
            $display("FAIL flush_addr_ar: unstable=%0d ar_cycles=%0d want 0/4", obs_ar_unstable, obs_ar_cyc);
        end
        n_cmp++;
        if (obs_ready_cnt !== 0 || obs_beats !== 4 || !obs_idle || line_data !== prev) begin
            n_err++;
            $display("FAIL flush_addr_drain: pulses=%0d beats=%0d idle=%0d line=%h want 0/4/1/%h",
                     obs_ready_cnt, obs_beats, obs_idle, line_data, prev);
        end
    endtask

    task automatic test_flush_done();
        new_beats();
        run_txn(32'h0000_4444, 1, 4, -1, 1);
        n_cmp++;
        if (obs_ready_cnt !== 0 || line_data !== beats_line() || !obs_idle || obs_extra_ar) begin
            n_err++;
            $display("FAIL flush_done: pulses=%0d line=%h idle=%0d extra_ar=%0d want 0/%h/1/0",
                     obs_ready_cnt, line_data, obs_idle, obs_extra_ar, beats_line());
        end
    endtask

    task automatic test_flush_idle();
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_5550; flush = 1'b1;
        @(negedge clk);
        idle_inputs();
        #1;
        n_cmp++;
        if (bus_arvalid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_idle: arvalid=%b want 0", bus_arvalid);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_protocol_err();
        new_beats();
        run_txn(32'h0000_6000, 0, -1, 1, 0);
        n_cmp++;
        if (obs_perr !== 1'b1 || obs_ready_cyc !== 6 || obs_line !== beats_line()) begin
            n_err++;
            $display("FAIL perr_early: perr=%b cycle=%0d line=%h want 1/6/%h",
                     obs_perr, obs_ready_cyc, obs_line, beats_line());
        end
        new_beats();
        run_txn(32'h0000_6100, 0, -1, -1, 0);
        n_cmp++;
        if (obs_perr !== 1'b1) begin
            n_err++;
            $display("FAIL perr_sticky: perr=%b want 1", obs_perr);
        end
        do_reset();
        #1;
        n_cmp++;
        if (protocol_err !== 1'b0) begin
            n_err++;
            $display("FAIL perr_reset: perr=%b want 0", protocol_err);
        end
        new_beats();
        run_txn(32'h0000_6200, 0, -1, 3, 1);
        n_cmp++;
        if (obs_perr !== 1'b1 || obs_ready_cnt !== 1) begin
            n_err++;
            $display("FAIL perr_missing_last: perr=%b pulses=%0d want 1/1", obs_perr, obs_ready_cnt);
        end
        do_reset();
    endtask

    task automatic test_reset_mid_burst();
        int beats;
        bit seen;
        beats = 0;
        seen  = 0;
        new_beats();
        for (int c = 0; c < 40 && beats < 2; c++) begin
            @(negedge clk);
            req_valid   = 1'b1;
            req_addr    = 32'h0000_7770;
            bus_arready = bus_arvalid;
            bus_rvalid  = bus_rready;
            bus_rdata   = beat_q[beats];
            bus_rlast   = 1'b0;
            #1;
            if (bus_rvalid && bus_rready) beats++;
        end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        seen = (beats == 2);
        n_cmp++;
        if (!seen || {line_ready, bus_arvalid, bus_rready, protocol_err} !== 4'b0 ||
            line_data !== 128'h0 || bus_araddr !== 32'h0 || bus_arlen !== 8'h0) begin
            n_err++;
            $display("FAIL reset_mid_burst: beats=%0d ctrl=%b line=%h araddr=%h arlen=%h want 2/0000/0/0/0",
                     beats, {line_ready, bus_arvalid, bus_rready, protocol_err}, line_data, bus_araddr, bus_arlen);
        end
        new_beats();
        run_txn(32'h0000_7788, 0, -1, -1, 0);
        n_cmp++;
        if (obs_ready_cyc !== 6 || obs_line !== beats_line()) begin
            n_err++;
            $display("FAIL reset_recover: cycle=%0d line=%h want 6/%h", obs_ready_cyc, obs_line, beats_line());
        end
    endtask

    task automatic test_random();
        logic [127:0] exp_line;
        bit           line_known;
        line_known = 0;
        exp_line   = '0;
        for (int it = 0; it < 30; it++) begin
            logic [31:0] addr;
            int          d, fa, r;
            bit          completes;
            addr = $urandom;
            d    = $urandom_range(0, 4);
            r    = $urandom_range(0, 9);
            fa   = (r >= 4 && r <= 8) ? r - 4 : -1;
            completes = (fa == -1);
            new_beats();
            run_txn(addr, d, fa, -1, 1);
            if (fa == -1 || fa == 4) begin
                exp_line   = beats_line();
                line_known = 1;
            end else if (fa != 0) begin
                line_known = 0;
            end
            n_cmp++;
            if (obs_timeout || obs_beats !== 4 || obs_araddr !== {addr[31:4], 4'h0} || obs_arlen !== 8'd3) begin
                n_err++;
                $display("FAIL rand_bus[%0d]: to=%0d beats=%0d araddr=%h arlen=%0d want 0/4/%h/3",
                         it, obs_timeout, obs_beats, obs_araddr, obs_arlen, {addr[31:4], 4'h0});
            end
            n_cmp++;
            if (obs_ar_unstable || obs_ar_cyc !== d + 1 || obs_extra_ar || !obs_idle || obs_perr) begin
                n_err++;
                $display("FAIL rand_ctrl[%0d]: unstable=%0d ar_cycles=%0d extra_ar=%0d idle=%0d perr=%0d want 0/%0d/0/1/0",
                         it, obs_ar_unstable, obs_ar_cyc, obs_extra_ar, obs_idle, obs_perr, d + 1);
            end
            n_cmp++;
            if (obs_ready_cnt !== (completes ? 1 : 0) ||
                (completes && (obs_ready_cyc !== 6 + d + obs_gaps || obs_line !== exp_line))) begin
                n_err++;
                $display("FAIL rand_ready[%0d]: flush_at=%0d pulses=%0d cycle=%0d line=%h want %0d/%0d/%h",
                         it, fa, obs_ready_cnt, obs_ready_cyc, obs_line, completes ? 1 : 0, 6 + d + obs_gaps, exp_line);
            end
            if (line_known) begin
                n_cmp++;
                if (line_data !== exp_line) begin
                    n_err++;
                    $display("FAIL rand_hold[%0d]: line=%h want %h", it, line_data, exp_line);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        do_reset();
        test_reset();
        test_basic();
        test_ar_stall();
        test_flush_data();
        test_flush_addr();
        test_flush_done();
        test_flush_idle();
        test_protocol_err();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
